// File: rtl/timer.sv
// Programmable down-counting timer with a memory-mapped CTRL/PRESET/COUNT
// register file, one-shot (Mode 0) or auto-reload (Mode 1) operation and a
// maskable interrupt request.
module timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t              state;
  logic [CTRL_W-1:0]   ctrl;
  logic [DATA_W-1:0]   preset;
  logic [DATA_W-1:0]   count;
  logic                irq_flag;

  logic                en;
  logic [1:0]          mode;
  logic                im;
  logic                wr_ctrl;
  logic                wr_preset;
  logic                unused_addr;

  assign en   = ctrl[0];
  assign mode = ctrl[2:1];
  assign im   = ctrl[3];

  // Only Addr[3:2] selects a register; the remaining address bits are don't-care.
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  // Bridge write strobes for the two writable registers.
  assign wr_ctrl   = WE && (Addr[3:2] == 2'd0);
  assign wr_preset = WE && (Addr[3:2] == 2'd1);

  // Interrupt is the masked pending flag; a mask change shows up at once.
  assign IRQ = im & irq_flag;

  // Combinational read mux, also live during reset so reads return zeros.
  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      2'd0:    Dout = {(DATA_W - CTRL_W)'(0), ctrl};
      2'd1:    Dout = preset;
      2'd2:    Dout = count;
      default: Dout = '0;
    endcase
  end

  // Register file and counter FSM; a same-edge CTRL write beats the FSM's
  // En clear, and the FSM's irq_flag set beats a write-triggered clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_ctrl || wr_preset) begin
        irq_flag <= 1'b0;
      end
      if (wr_preset) begin
        preset <= Din;
      end

      case (state)
        S_IDLE: begin
          if (en) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (count > DATA_W'(1)) begin
            count <= count - DATA_W'(1);
          end else begin
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= S_INT;
          end
        end
        S_INT: begin
          if (mode == 2'd1) begin
            irq_flag <= 1'b0;
          end else begin
            ctrl[0] <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (wr_ctrl) begin
        ctrl <= Din[CTRL_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for the timer: a register-map vector table followed by
// hand-timed sequences for one-shot, auto-reload, masking, stop/restart,
// zero preset, same-edge races and asynchronous reset.
module tb_timer;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_cmp;
  int n_bad;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_PRESET = 32'h4;
  localparam logic [31:0] A_COUNT  = 32'h8;
  localparam logic [31:0] A_RSVD   = 32'hC;

  timer dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(name, Dout, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    chk(name, {31'd0, IRQ}, {31'd0, exp});
  endtask

  // One bus write; returns 1 ns after the edge that performs it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    logic [31:0] cnt_by_p[6];
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;

    // Reset state, before and across clock edges.
    #3;
    rd("rst_ctrl", A_CTRL, 32'h0);
    rd("rst_preset", A_PRESET, 32'h0);
    rd("rst_count", A_COUNT, 32'h0);
    chk_irq("rst_irq", 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Register map vectors; En stays 0 so the counter never runs.
    vecs[0] = '{1'b1, A_PRESET,      32'h12345678, A_PRESET, 32'h12345678};
    vecs[1] = '{1'b1, A_CTRL,        32'hFFFFFFF6, A_CTRL,   32'h00000006};
    vecs[2] = '{1'b1, A_COUNT,       32'hDEADBEEF, A_COUNT,  32'h00000000};
    vecs[3] = '{1'b1, A_RSVD,        32'hFFFFFFFF, A_RSVD,   32'h00000000};
    vecs[4] = '{1'b0, A_PRESET,      32'h00000000, A_PRESET, 32'h12345678};
    vecs[5] = '{1'b1, 32'hFFFF0014,  32'hA5A5A5A5, A_PRESET, 32'hA5A5A5A5};
    vecs[6] = '{1'b1, A_CTRL,        32'h00000000, A_CTRL,   32'h00000000};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      Addr = vecs[i].addr;
      Din  = vecs[i].din;
      WE   = vecs[i].we;
      @(posedge clk);
      #1;
      WE = 1'b0;
      rd($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
      chk_irq($sformatf("vec%0d_irq", i), 1'b0);
    end

    // Scenario 1: one-shot, PRESET=5, IRQ 7 edges after the CTRL write.
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    chk_irq("s1_irq_t0", 1'b0);
    step(1);
    rd("s1_count_load", A_COUNT, 32'd0);
    step(1);
    rd("s1_count_n", A_COUNT, 32'd5);
    step(4);
    rd("s1_count_1", A_COUNT, 32'd1);
    chk_irq("s1_irq_t6", 1'b0);
    step(1);
    chk_irq("s1_irq_t7", 1'b1);
    rd("s1_count_0", A_COUNT, 32'd0);
    rd("s1_ctrl_int", A_CTRL, 32'h9);
    step(1);
    rd("s1_ctrl_en_clr", A_CTRL, 32'h8);
    chk_irq("s1_irq_t8", 1'b1);
    step(3);
    chk_irq("s1_irq_held", 1'b1);
    rd("s1_count_hold", A_COUNT, 32'd0);
    wr(A_CTRL, 32'h0);
    chk_irq("s1_irq_drop", 1'b0);

    // Scenario 2: auto-reload, PRESET=3, period 6, single-cycle pulses.
    cnt_by_p[0] = 32'd0; cnt_by_p[1] = 32'd0; cnt_by_p[2] = 32'd0;
    cnt_by_p[3] = 32'd3; cnt_by_p[4] = 32'd2; cnt_by_p[5] = 32'd1;
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      p = (k + 1) % 6;
      chk_irq($sformatf("s2_irq_k%0d", k), p == 0);
      rd($sformatf("s2_count_k%0d", k), A_COUNT, cnt_by_p[p]);
    end
    wr(A_CTRL, 32'h0);
    step(2);

    // Scenario 3: masked one-shot, then PRESET write clears the flag.
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h1);
    step(4);
    chk_irq("s3_irq_masked", 1'b0);
    rd("s3_ctrl_int", A_CTRL, 32'h1);
    step(1);
    rd("s3_ctrl_en_clr", A_CTRL, 32'h0);
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h8);
    chk_irq("s3_irq_after_im", 1'b0);
    wr(A_CTRL, 32'h0);

    // Scenario 4: stop mid-count, freeze, then restart reloads PRESET.
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h1);
    step(4);
    rd("s4_count_8", A_COUNT, 32'd8);
    wr(A_CTRL, 32'h0);
    rd("s4_count_stop", A_COUNT, 32'd7);
    step(1);
    rd("s4_count_frz1", A_COUNT, 32'd7);
    step(3);
    rd("s4_count_frz2", A_COUNT, 32'd7);
    wr(A_CTRL, 32'h1);
    step(1);
    rd("s4_count_load", A_COUNT, 32'd7);
    step(1);
    rd("s4_count_reload", A_COUNT, 32'd10);
    wr(A_CTRL, 32'h0);
    step(2);

    // Scenario 5: PRESET=0 reaches INT 3 edges after enable, no wrap.
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);
    step(1);
    chk_irq("s5_irq_k1", 1'b0);
    step(1);
    chk_irq("s5_irq_k2", 1'b0);
    rd("s5_count_k2", A_COUNT, 32'd0);
    step(1);
    chk_irq("s5_irq_k3", 1'b1);
    rd("s5_count_k3", A_COUNT, 32'd0);
    step(1);
    rd("s5_count_k4", A_COUNT, 32'd0);
    rd("s5_ctrl_k4", A_CTRL, 32'h8);
    wr(A_PRESET, 32'd7);
    chk_irq("s5_preset_clears", 1'b0);
    rd("s5_preset_rd", A_PRESET, 32'd7);
    rd("s5_count_untouched", A_COUNT, 32'd0);

    // CTRL write on the INT edge beats the FSM's En clear.
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);
    step(3);
    wr(A_CTRL, 32'h9);
    rd("race_ctrl_wins", A_CTRL, 32'h9);
    chk_irq("race_irq_clr", 1'b0);
    step(2);
    chk_irq("race_rerun_k6", 1'b0);
    step(1);
    chk_irq("race_rerun_k7", 1'b1);
    wr(A_CTRL, 32'h0);
    chk_irq("race_clean", 1'b0);

    // PRESET write on the edge that enters INT: the set wins.
    wr(A_CTRL, 32'h9);
    step(2);
    wr(A_PRESET, 32'd0);
    chk_irq("set_wins", 1'b1);
    wr(A_CTRL, 32'h0);

    // Scenario 6: asynchronous reset while in INT with IRQ high.
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    step(5);
    chk_irq("s6_irq_pre", 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_irq("s6_irq_rst", 1'b0);
    rd("s6_ctrl_rst", A_CTRL, 32'h0);
    rd("s6_preset_rst", A_PRESET, 32'h0);
    rd("s6_count_rst", A_COUNT, 32'h0);
    step(2);
    chk_irq("s6_irq_hold", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    wr(A_PRESET, 32'd4);
    step(4);
    rd("s6_count_idle", A_COUNT, 32'd0);
    rd("s6_ctrl_idle", A_CTRL, 32'h0);
    chk_irq("s6_irq_idle", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
